pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/target/EPC width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, meaning PC value after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h100, meaning PC value loaded on any trap.
REQ-004 SHALL have parameter COMPRESSED, default 0, meaning 1 enables 16-bit instruction support (2-byte alignment, +2 step).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port PCTarget  in  XLEN  branch/jump target.
REQ-008 SHALL have port PCSrc  in  1  1 = redirect to PCTarget.
REQ-009 SHALL have port stall  in  1  1 = hold PC (pipeline stall).
REQ-010 SHALL have port trap  in  1  1 = external/ecall trap request.
REQ-011 SHALL have port mret  in  1  1 = return from trap to epc.
REQ-012 SHALL have port halt_req  in  1  1 = enter HALT state.
REQ-013 SHALL have port resume  in  1  1 = leave HALT state.
REQ-014 SHALL have port inst_len16  in  1  1 = current instruction is 16-bit; ignored when COMPRESSED=0.
REQ-015 SHALL have port program_counter  out  XLEN  current fetch PC (registered).
REQ-016 SHALL have port epc  out  XLEN  saved PC of last trap (registered).
REQ-017 SHALL have port misaligned  out  1  one-cycle registered pulse: last redirect target misaligned.
REQ-018 SHALL have port halted  out  1  1 while in HALT state.
REQ-019 SHALL have port pc_updates  out  32  count of PC changes since reset, wraps modulo 2^32.

Function
REQ-020 SHALL implement two states: RUN, HALT; halted = (state == HALT).
REQ-021 In RUN, next-PC SHALL follow strict priority: trap > misaligned redirect > mret > PCSrc > stall > sequential step.
REQ-022 trap=1: program_counter <= TRAP_VECTOR, epc <= program_counter (current value).
REQ-023 Misaligned redirect = PCSrc=1 and PCTarget[1:0]!=0 (COMPRESSED=0) or PCTarget[0]!=0 (COMPRESSED=1); SHALL behave as trap (TRAP_VECTOR, epc <= program_counter) and set misaligned=1 for exactly the next cycle.
REQ-024 mret=1 (no trap/misaligned): program_counter <= epc; epc unchanged.
REQ-025 PCSrc=1 with aligned target: program_counter <= PCTarget.
REQ-026 stall=1 with no higher-priority event: program_counter holds; stall does NOT block trap, mret or PCSrc.
REQ-027 Sequential step: +4, or +2 when COMPRESSED=1 and inst_len16=1; addition modulo 2^XLEN (all-ones region wraps to 0, no flag).
REQ-028 halt_req=1 in RUN: transition to HALT next cycle; the PC update of that same cycle still occurs per REQ-021.
REQ-029 In HALT: program_counter, epc, pc_updates hold; trap, mret, PCSrc, stall ignored; resume=1 returns to RUN next cycle with no PC change that cycle.
REQ-030 halt_req and resume both 1 in HALT: resume wins; both 1 in RUN: halt_req wins.
REQ-031 pc_updates SHALL increment by 1 on every cycle where program_counter takes a new assignment other than hold (same-value redirect still counts).
REQ-032 misaligned SHALL be 0 in every cycle not following a misaligned redirect.

Reset
REQ-033 reset=1 at a rising edge SHALL set program_counter=RESET_VECTOR, epc=0, misaligned=0, pc_updates=0, state=RUN, overriding all other inputs including mid-HALT and mid-trap.
REQ-034 Outputs SHALL be undefined-free (no X) from the first edge with reset=1.

Verification
REQ-035 Reset 2 cycles then idle 3 cycles -> program_counter 0,4,8,12; pc_updates=3.
REQ-036 PC=0x20, PCSrc=1, PCTarget=0x1002 (COMPRESSED=0) -> PC=0x100, epc=0x20, misaligned=1 one cycle; then mret -> PC=0x20.
REQ-037 PC=0x40, trap=1 and PCSrc=1 and stall=1 same cycle -> PC=0x100, epc=0x40; PCTarget ignored.
REQ-038 PC=0x80, halt_req=1 -> halted=1, PC holds 0x84 for 5 cycles despite PCSrc=1; resume=1 -> next cycle PC=0x84, then 0x88.
REQ-039 COMPRESSED=1, PC=0x10, inst_len16=1,0,1 -> PC 0x12,0x16,0x18; PCTarget=0x1FE accepted, 0x1FF misaligned trap.
REQ-040 XLEN=32, PC=0xFFFFFFFC, sequential step -> PC=0x0; reset asserted during HALT -> PC=RESET_VECTOR, halted=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC selection, trap/mret handling,
// misaligned-redirect detection and a RUN/HALT control state machine.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter bit              COMPRESSED   = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            PCSrc,
  input  logic            stall,
  input  logic            trap,
  input  logic            mret,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            inst_len16,
  output logic [XLEN-1:0] program_counter,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic            halted,
  output logic [31:0]     pc_updates
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc_n, epc_n, step;
  logic [CNT_W-1:0]  upd_n;
  logic              mis_n, target_bad;

  // State and datapath registers; reset overrides everything, even mid-HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RUN;
      program_counter <= RESET_VECTOR;
      epc             <= '0;
      misaligned      <= 1'b0;
      pc_updates      <= '0;
    end else begin
      state           <= state_n;
      program_counter <= pc_n;
      epc             <= epc_n;
      misaligned      <= mis_n;
      pc_updates      <= upd_n;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_n    = state;
    pc_n       = program_counter;
    epc_n      = epc;
    mis_n      = 1'b0;
    upd_n      = pc_updates;
    target_bad = COMPRESSED ? PCTarget[0] : (PCTarget[1:0] != 2'b00);
    step       = (COMPRESSED && inst_len16) ? XLEN'(2) : XLEN'(4);

    case (state)
      RUN: begin
        if (trap) begin
          pc_n  = TRAP_VECTOR;
          epc_n = program_counter;
        end else if (PCSrc && target_bad) begin
          pc_n  = TRAP_VECTOR;
          epc_n = program_counter;
          mis_n = 1'b1;
        end else if (mret) begin
          pc_n = epc;
        end else if (PCSrc) begin
          pc_n = PCTarget;
        end else if (!stall) begin
          pc_n = program_counter + step;
        end
        // Any non-hold assignment counts, even when the value is unchanged.
        if (trap || PCSrc || mret || !stall) begin
          upd_n = pc_updates + CNT_W'(1);
        end
        if (halt_req) begin
          state_n = HALT;
        end
      end
      HALT: begin
        if (resume) begin
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized stimulus
// compared each cycle against a behavioural model, on a 4-byte and a 2-byte-aligned instance.
module tb_pc_unit;

  localparam logic [31:0] TRAP_VEC = 32'h100;

  logic        clk = 1'b0;
  logic        reset, PCSrc, stall, trap, mret, halt_req, resume, inst_len16;
  logic [31:0] PCTarget;

  logic [31:0] pc0, epc0, upd0, pc1, epc1, upd1;
  logic        mis0, halted0, mis1, halted1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, index 0 = 4-byte instance, 1 = compressed instance.
  logic [31:0] m_pc  [2];
  logic [31:0] m_epc [2];
  logic [31:0] m_upd [2];
  logic        m_mis [2];
  logic        m_halt[2];

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP_VEC), .COMPRESSED(1'b0)) dut0 (
    .clk(clk), .reset(reset), .PCTarget(PCTarget), .PCSrc(PCSrc), .stall(stall),
    .trap(trap), .mret(mret), .halt_req(halt_req), .resume(resume), .inst_len16(inst_len16),
    .program_counter(pc0), .epc(epc0), .misaligned(mis0), .halted(halted0), .pc_updates(upd0)
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP_VEC), .COMPRESSED(1'b1)) dut1 (
    .clk(clk), .reset(reset), .PCTarget(PCTarget), .PCSrc(PCSrc), .stall(stall),
    .trap(trap), .mret(mret), .halt_req(halt_req), .resume(resume), .inst_len16(inst_len16),
    .program_counter(pc1), .epc(epc1), .misaligned(mis1), .halted(halted1), .pc_updates(upd1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of architectural behaviour for one instance.
  task automatic model_step(input int k, input bit comp);
    bit bad_target;
    if (reset) begin
      m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_upd[k] = 32'h0;
      m_mis[k] = 1'b0; m_halt[k] = 1'b0;
      return;
    end
    m_mis[k] = 1'b0;
    if (m_halt[k]) begin
      if (resume) m_halt[k] = 1'b0;
      return;
    end
    bad_target = PCSrc && ((comp ? (PCTarget % 2) : (PCTarget % 4)) != 0);
    if (trap || bad_target) begin
      m_epc[k] = m_pc[k];
      m_pc[k]  = TRAP_VEC;
      m_mis[k] = !trap;
      m_upd[k]++;
    end else if (mret) begin
      m_pc[k] = m_epc[k];
      m_upd[k]++;
    end else if (PCSrc) begin
      m_pc[k] = PCTarget;
      m_upd[k]++;
    end else if (!stall) begin
      m_pc[k] = m_pc[k] + ((comp && inst_len16) ? 32'd2 : 32'd4);
      m_upd[k]++;
    end
    if (halt_req) m_halt[k] = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
    check("pc0",  pc0,  m_pc[0]);
    check("epc0", epc0, m_epc[0]);
    check("upd0", upd0, m_upd[0]);
    check("mis0", 32'(mis0), 32'(m_mis[0]));
    check("hlt0", 32'(halted0), 32'(m_halt[0]));
    check("pc1",  pc1,  m_pc[1]);
    check("epc1", epc1, m_epc[1]);
    check("upd1", upd1, m_upd[1]);
    check("mis1", 32'(mis1), 32'(m_mis[1]));
    check("hlt1", 32'(halted1), 32'(m_halt[1]));
  endtask

  task automatic idle_inputs();
    PCSrc = 0; stall = 0; trap = 0; mret = 0; halt_req = 0; resume = 0;
    inst_len16 = 0; PCTarget = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    check("rst_pc", pc0, 32'h0);
    repeat (3) cycle();
    check("seq_pc", pc0, 32'hC);
    check("seq_upd", upd0, 32'd3);

    // Misaligned redirect then mret back.
    do_reset();
    repeat (8) cycle();
    PCSrc = 1; PCTarget = 32'h1002;
    cycle();
    PCSrc = 0;
    check("misal_pc", pc0, 32'h100);
    check("misal_epc", epc0, 32'h20);
    check("misal_flag", 32'(mis0), 32'd1);
    check("c_aligned_pc", pc1, 32'h1002);
    mret = 1;
    cycle();
    mret = 0;
    check("mret_pc", pc0, 32'h20);
    check("mis_clear", 32'(mis0), 32'd0);

    // Trap beats redirect and stall.
    do_reset();
    repeat (16) cycle();
    trap = 1; PCSrc = 1; stall = 1; PCTarget = 32'h2000;
    cycle();
    idle_inputs();
    check("trap_pc", pc0, 32'h100);
    check("trap_epc", epc0, 32'h40);

    // Halt holds the PC against redirects; resume restarts stepping.
    do_reset();
    repeat (32) cycle();
    halt_req = 1;
    cycle();
    halt_req = 0;
    check("halt_flag", 32'(halted0), 32'd1);
    check("halt_pc", pc0, 32'h84);
    PCSrc = 1; trap = 1; PCTarget = 32'h3000;
    repeat (5) cycle();
    check("halt_hold", pc0, 32'h84);
    idle_inputs();
    resume = 1;
    cycle();
    resume = 0;
    check("resume_pc", pc0, 32'h84);
    check("resume_flag", 32'(halted0), 32'd0);
    cycle();
    check("after_resume", pc0, 32'h88);

    // Compressed stepping and 2-byte alignment.
    do_reset();
    repeat (4) cycle();
    inst_len16 = 1; cycle(); check("c_step1", pc1, 32'h12);
    inst_len16 = 0; cycle(); check("c_step2", pc1, 32'h16);
    inst_len16 = 1; cycle(); check("c_step3", pc1, 32'h18);
    inst_len16 = 0;
    PCSrc = 1; PCTarget = 32'h1FE; cycle();
    check("c_tgt_ok", pc1, 32'h1FE);
    PCTarget = 32'h1FF; cycle();
    PCSrc = 0;
    check("c_tgt_bad", pc1, 32'h100);
    check("c_mis", 32'(mis1), 32'd1);

    // Wraparound, then reset while halted.
    PCSrc = 1; PCTarget = 32'hFFFF_FFFC; cycle();
    PCSrc = 0; cycle();
    check("wrap0", pc0, 32'h0);
    check("wrap1", pc1, 32'h0);
    halt_req = 1; cycle(); halt_req = 0;
    reset = 1; cycle(); reset = 0;
    check("rst_halt_pc", pc0, 32'h0);
    check("rst_halt_flag", 32'(halted0), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      trap       = ($urandom_range(0, 31) == 0);
      mret       = ($urandom_range(0, 15) == 0);
      PCSrc      = ($urandom_range(0, 3) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      halt_req   = ($urandom_range(0, 31) == 0);
      resume     = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 127) == 0);
      inst_len16 = 1'($urandom_range(0, 1));
      PCTarget   = $urandom;
      if ($urandom_range(0, 1) == 1) PCTarget = PCTarget & 32'hFFFF_FFFC;
      cycle();
    end
    reset = 0;
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
